// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file: the operation
// field type and its encodings.
package gpr_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_LOAD = 3'b000;
    localparam op_t OP_INC  = 3'b001;
    localparam op_t OP_DEC  = 3'b010;
    localparam op_t OP_SHL  = 3'b011;
    localparam op_t OP_SHR  = 3'b100;
    localparam op_t OP_CLR  = 3'b101;

endpackage

// File: rtl/gpr_file_if.sv
// Write/read control bundle for the register file. The tri-state data outputs
// are kept as plain ports on the top so their Z state resolves on a real net.
interface gpr_file_if
    import gpr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             wa;
    logic [AW-1:0]    waddr;
    op_t              op;
    logic [WIDTH-1:0] data_in;
    logic             oa;
    logic [AW-1:0]    raddr_a;
    logic             ob;
    logic [AW-1:0]    raddr_b;
    logic             zero_flag;
    logic             carry_flag;

    modport master (
        output wa, waddr, op, data_in, oa, raddr_a, ob, raddr_b,
        input  zero_flag, carry_flag
    );

    modport slave (
        input  wa, waddr, op, data_in, oa, raddr_a, ob, raddr_b,
        output zero_flag, carry_flag
    );

endinterface

// File: rtl/gpr_alu.sv
// In-place operation unit: computes the new register value and flags from the
// current register contents. Reserved encodings report valid=0.
module gpr_alu
    import gpr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] data_in,
    input  op_t              op,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             valid
);

    always_comb begin
        res   = cur;
        carry = 1'b0;
        valid = 1'b1;
        case (op)
            OP_LOAD: res = data_in;
            OP_INC: begin
                res   = cur + WIDTH'(1);
                carry = &cur;
            end
            OP_DEC: begin
                res   = cur - WIDTH'(1);
                carry = ~|cur;
            end
            OP_SHL: begin
                res   = {cur[WIDTH-2:0], 1'b0};
                carry = cur[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, cur[WIDTH-1:1]};
                carry = cur[0];
            end
            OP_CLR: res = '0;
            default: valid = 1'b0;
        endcase
        zero = ~|res;
    end

endmodule

// File: rtl/gpr_file.sv
// DEPTH x WIDTH register file with one operate-in-place write port, status
// flags, and two independently enabled tri-state read ports.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    gpr_file_if.slave        bus,
    output wire [WIDTH-1:0]  data_out_a,
    output wire [WIDTH-1:0]  data_out_b
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             hit;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_valid;
    logic             zero_q;
    logic             carry_q;

    // Address decode by compare so out-of-range addresses simply match nothing.
    always_comb begin
        cur = '0;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.waddr == AW'(i)) begin
                cur = regs[i];
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr_a == AW'(i)) rd_a = regs[i];
            if (bus.raddr_b == AW'(i)) rd_b = regs[i];
        end
    end

    gpr_alu #(.WIDTH(WIDTH)) u_alu (
        .cur     (cur),
        .data_in (bus.data_in),
        .op      (bus.op),
        .res     (res),
        .carry   (alu_carry),
        .zero    (alu_zero),
        .valid   (alu_valid)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (bus.wa && hit && alu_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.waddr == AW'(i)) regs[i] <= res;
            end
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
        end
    end

    assign bus.zero_flag  = zero_q;
    assign bus.carry_flag = carry_q;

    assign data_out_a = bus.oa ? rd_a : {WIDTH{1'bz}};
    assign data_out_b = bus.ob ? rd_b : {WIDTH{1'bz}};

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: a DEPTH=4 instance for the main sequence and a
// DEPTH=3 instance for out-of-range addressing.
module tb_gpr_file;
    import gpr_pkg::*;

    logic clk = 1'b0;
    logic clr;
    logic clr3;
    int   total = 0;
    int   bad   = 0;

    wire [7:0] da;
    wire [7:0] db;
    wire [7:0] d3a;
    wire [7:0] d3b;

    gpr_file_if #(.WIDTH(8), .DEPTH(4)) bus ();
    gpr_file_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

    gpr_file #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus),
        .data_out_a (da),
        .data_out_b (db)
    );

    gpr_file #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk        (clk),
        .clr        (clr3),
        .bus        (bus3),
        .data_out_a (d3a),
        .data_out_b (d3b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A released net may resolve to Z or, in a two-state simulator, to 0;
    // either shows the port is not driving the stored non-zero value.
    task automatic chk_z(input string tag, input logic [7:0] obs);
        total++;
        assert ((obs === 8'hzz) || (obs === 8'h00))
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=zz", tag, obs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1; clr3 = 1'b1;
        bus.wa = 1'b0; bus.waddr = '0; bus.op = OP_LOAD; bus.data_in = '0;
        bus.oa = 1'b0; bus.raddr_a = '0; bus.ob = 1'b0; bus.raddr_b = '0;
        bus3.wa = 1'b0; bus3.waddr = '0; bus3.op = OP_LOAD; bus3.data_in = '0;
        bus3.oa = 1'b0; bus3.raddr_a = '0; bus3.ob = 1'b0; bus3.raddr_b = '0;
        step();
        clr = 1'b0; clr3 = 1'b0;

        // reset then read
        bus.oa = 1'b1; bus.ob = 1'b1; bus.raddr_a = 2'd0; bus.raddr_b = 2'd3;
        #1;
        chk("rst_a", da, 8'h00);
        chk("rst_b", db, 8'h00);
        chk("rst_zf", bus.zero_flag, 1'b0);
        chk("rst_cf", bus.carry_flag, 1'b0);

        // loads and dual read
        bus.wa = 1'b1; bus.op = OP_LOAD; bus.waddr = 2'd1; bus.data_in = 8'hA5;
        step();
        bus.waddr = 2'd2; bus.data_in = 8'h3C;
        step();
        bus.wa = 1'b0;
        bus.raddr_a = 2'd1; bus.raddr_b = 2'd2;
        #1;
        chk("load_a", da, 8'hA5);
        chk("load_b", db, 8'h3C);
        chk("load_zf", bus.zero_flag, 1'b0);
        bus.oa = 1'b0;
        #1;
        chk_z("oe_off_a", da);
        bus.oa = 1'b1;
        #1;
        chk("oe_on_a", da, 8'hA5);

        // same-cycle read/write, no bypass
        bus.wa = 1'b1; bus.op = OP_LOAD; bus.waddr = 2'd1; bus.data_in = 8'h11;
        #1;
        chk("rw_pre", da, 8'hA5);
        step();
        chk("rw_post", da, 8'h11);

        // wrap boundaries on r0
        bus.raddr_a = 2'd0;
        bus.op = OP_LOAD; bus.waddr = 2'd0; bus.data_in = 8'hFF;
        step();
        bus.op = OP_INC;
        step();
        chk("inc_wrap", da, 8'h00);
        chk("inc_zf", bus.zero_flag, 1'b1);
        chk("inc_cf", bus.carry_flag, 1'b1);
        bus.op = OP_DEC;
        step();
        chk("dec_wrap", da, 8'hFF);
        chk("dec_zf", bus.zero_flag, 1'b0);
        chk("dec_cf", bus.carry_flag, 1'b1);
        step();
        chk("dec_plain", da, 8'hFE);
        chk("dec_cf0", bus.carry_flag, 1'b0);
        bus.op = OP_INC;
        step();
        chk("inc_chain1", da, 8'hFF);
        chk("inc_chain1_cf", bus.carry_flag, 1'b0);
        step();
        chk("inc_chain2", da, 8'h00);
        chk("inc_chain2_cf", bus.carry_flag, 1'b1);

        // shifts on r3
        bus.raddr_b = 2'd3;
        bus.op = OP_LOAD; bus.waddr = 2'd3; bus.data_in = 8'h81;
        step();
        bus.op = OP_SHL;
        step();
        chk("shl", db, 8'h02);
        chk("shl_cf", bus.carry_flag, 1'b1);
        chk("shl_zf", bus.zero_flag, 1'b0);
        bus.op = OP_SHR;
        step();
        chk("shr1", db, 8'h01);
        chk("shr1_cf", bus.carry_flag, 1'b0);
        step();
        chk("shr2", db, 8'h00);
        chk("shr2_zf", bus.zero_flag, 1'b1);
        chk("shr2_cf", bus.carry_flag, 1'b1);

        // reserved ops: no write, flags held at 1/1
        bus.op = 3'b110; bus.waddr = 2'd3; bus.data_in = 8'h5A;
        step();
        chk("rsv6_reg", db, 8'h00);
        chk("rsv6_zf", bus.zero_flag, 1'b1);
        chk("rsv6_cf", bus.carry_flag, 1'b1);
        bus.raddr_a = 2'd1;
        bus.op = 3'b111; bus.waddr = 2'd1;
        step();
        chk("rsv7_reg", da, 8'h11);
        chk("rsv7_cf", bus.carry_flag, 1'b1);

        // wa=0 holds registers and flags
        bus.wa = 1'b0; bus.op = OP_LOAD; bus.data_in = 8'h77;
        step();
        chk("hold_reg", da, 8'h11);
        chk("hold_zf", bus.zero_flag, 1'b1);
        chk("hold_cf", bus.carry_flag, 1'b1);

        // CLR operation
        bus.wa = 1'b1; bus.op = OP_CLR;
        step();
        chk("opclr_reg", da, 8'h00);
        chk("opclr_zf", bus.zero_flag, 1'b1);
        chk("opclr_cf", bus.carry_flag, 1'b0);

        // reset priority over a concurrent load
        bus.op = OP_LOAD; bus.waddr = 2'd2; bus.data_in = 8'h00;
        bus.op = OP_DEC; bus.waddr = 2'd0;
        step();
        chk("pre_clr_cf", bus.carry_flag, 1'b1);
        clr = 1'b1; bus.op = OP_LOAD; bus.waddr = 2'd1; bus.data_in = 8'h77;
        step();
        clr = 1'b0; bus.wa = 1'b0; bus.raddr_b = 2'd0;
        #1;
        chk("clrpri_r1", da, 8'h00);
        chk("clrpri_r0", db, 8'h00);
        chk("clrpri_zf", bus.zero_flag, 1'b0);
        chk("clrpri_cf", bus.carry_flag, 1'b0);

        // out-of-range addressing on the DEPTH=3 instance
        bus3.wa = 1'b1; bus3.op = OP_LOAD;
        bus3.waddr = 2'd0; bus3.data_in = 8'h12;
        step();
        bus3.waddr = 2'd1; bus3.data_in = 8'h34;
        step();
        bus3.waddr = 2'd2; bus3.data_in = 8'h00;
        step();
        bus3.waddr = 2'd3; bus3.data_in = 8'h55;
        step();
        bus3.wa = 1'b0;
        bus3.oa = 1'b1; bus3.raddr_a = 2'd3;
        bus3.ob = 1'b1; bus3.raddr_b = 2'd0;
        #1;
        chk("oor_read", d3a, 8'h00);
        chk("oor_zf", bus3.zero_flag, 1'b1);
        chk("oor_r0", d3b, 8'h12);
        bus3.raddr_b = 2'd1;
        #1;
        chk("oor_r1", d3b, 8'h34);
        bus3.raddr_b = 2'd2;
        #1;
        chk("oor_r2", d3b, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_file.md
# gpr_file

Parametrised general-purpose register file: DEPTH registers of WIDTH bits, one write port with a small in-place operation unit, and two independently enabled tri-state read ports. It replaces single-register instances where a datapath needs several registers sharing one bus. It also adds increment, decrement, shift and status-flag behaviour. It sits between the system data bus and the ALU and drives the shared bus only when a read port is enabled.

## Interface
- WIDTH, 8, data width of each register (min 2)
- DEPTH, 4, number of registers (min 2; non-power-of-2 allowed)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high; priority over all other inputs
- wa  in  1  write enable; operation `op` applied to register `waddr` at the clock edge
- waddr  in  AW  target register of write/operation
- op  in  3  operation select (see Operation)
- data_in  in  WIDTH  load data
- oa  in  1  output enable, port A
- raddr_a  in  AW  read address, port A
- data_out_a  out  WIDTH  register[raddr_a] when oa=1, else all-Z
- ob  in  1  output enable, port B
- raddr_b  in  AW  read address, port B
- data_out_b  out  WIDTH  register[raddr_b] when ob=1, else all-Z
- zero_flag  out  1  registered; 1 if last executed operation produced result 0
- carry_flag  out  1  registered; carry/borrow/shifted-out bit of last executed operation

## Operation
- Operations, applied when wa=1 and clr=0, result R written to register[waddr]:
  - 000 LOAD: R = data_in; carry = 0
  - 001 INC: R = reg+1 mod 2^WIDTH; carry = 1 only on wrap from all-ones to 0
  - 010 DEC: R = reg-1 mod 2^WIDTH; carry (borrow) = 1 only on wrap from 0 to all-ones
  - 011 SHL: R = {reg[WIDTH-2:0],0}; carry = reg[WIDTH-1]
  - 100 SHR: R = {0,reg[WIDTH-1:1]}; carry = reg[0]
  - 101 CLR: R = 0; carry = 0
  - 110, 111 reserved: no register write; flags unchanged
- zero_flag = (R == 0) for every executed (non-reserved) operation.
- Flags hold their value when wa=0 or op is reserved.
- waddr >= DEPTH: no write, flags unchanged. raddr >= DEPTH: port drives 0 when enabled.
- Read ports are combinational from register state. Both ports may read the same register, each with its own enable.
- clr=1: all registers, zero_flag and carry_flag cleared to 0 at the edge. wa is ignored that cycle.

## Timing
- Reset values: every register 0, zero_flag=0, carry_flag=0. data_out_a/b are Z unless oa/ob=1; with enable high after reset they read 0.
- Write latency: 1 cycle. The result is visible on read ports and flags after the same rising edge.
- Same-cycle read and write of the same address: the read port shows the pre-write value until the edge, then the new value. There is no bypass.
- Output enable is combinational. The Z-to-data transition happens in the same cycle oa/ob rises.
- Back-to-back operations on one register chain with no stall. For example, INC on consecutive cycles increments once per cycle.
- clr asserted mid-sequence overrides a concurrent wa. The operation is discarded, and the next cycle starts from all-zero state.

## Structure
- Package gpr_pkg: op encoding constants (OP_LOAD … OP_CLR) and a typedef for the 3-bit op field.
- Sub-module gpr_alu: purely combinational. Inputs are current register value, data_in and op; outputs are R, carry, zero and a "valid op" bit. The top level holds the register array, write decode, flag registers and tri-state read muxes.

## Test plan
- Reset then read: clr=1 one cycle, then oa=ob=1, raddr_a=0, raddr_b=DEPTH-1 -> both ports 0x00, flags 0/0. oa=0 -> data_out_a all-Z.
- Load and dual read: LOAD 0xA5 to r1, LOAD 0x3C to r2. raddr_a=1, raddr_b=2 -> 0xA5 / 0x3C. Same-cycle read of r1 during LOAD 0x11 shows 0xA5 before the edge and 0x11 after.
- Wrap boundaries: LOAD 0xFF to r0, INC -> r0=0x00, zero=1, carry=1. DEC -> r0=0xFF, zero=0, carry=1. DEC -> 0xFE, carry=0.
- Shifts: LOAD 0x81 to r3. SHL -> 0x02, carry=1. SHR -> 0x01, carry=0. SHR -> 0x00, zero=1, carry=1.
- Reserved/out-of-range/hold: op=110 with wa=1 leaves registers and flags unchanged. With DEPTH=3, waddr=3 LOAD 0x55 -> no change, and raddr=3 reads 0. wa=0 holds flags.
- Reset priority: clr=1 with wa=1 LOAD 0x77 to r1 -> r1=0x00, flags 0/0 next cycle.
